// File: rtl/drum_audio_bridge.sv
// rtl/drum_audio_bridge.sv - solver middle-node to codec sample bridge:
// saturating gain conversion, sample FIFO and prime/run rate decoupling.
module drum_audio_bridge #(
  parameter int DATA_WIDTH  = 18,
  parameter int AUDIO_WIDTH = 16,
  parameter int GAIN_SHIFT  = 2,
  parameter int FIFO_DEPTH  = 8,
  parameter int PRIME_LEVEL = 4,
  localparam int CW = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [DATA_WIDTH-1:0]  node_in,
  input  logic                   node_valid,
  input  logic                   audio_req,
  output logic [AUDIO_WIDTH-1:0] audio_data,
  output logic                   audio_strobe,
  output logic [CW-1:0]          fifo_count,
  output logic                   overflow_flag,
  output logic                   underflow_flag,
  input  logic                   clear_flags
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int XW = DATA_WIDTH + GAIN_SHIFT;

  typedef enum logic {
    ST_PRIME = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic                   conv_valid_q;
  logic [AUDIO_WIDTH-1:0] conv_data_q;
  logic [AUDIO_WIDTH-1:0] conv_d;
  logic [AUDIO_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]          wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]          count_q, count_d;
  logic [AUDIO_WIDTH-1:0] audio_data_q, audio_data_d;
  logic                   audio_strobe_q, audio_strobe_d;
  logic                   overflow_q, underflow_q;

  logic signed [XW-1:0]   ext;
  logic signed [XW-1:0]   shifted;
  logic [GAIN_SHIFT:0]    top;
  logic                   full, empty;
  logic                   push, pop;
  logic                   overflow_evt, underflow_evt;

  // Saturate whenever the gain pushed significant bits past the sign position.
  always_comb begin
    ext     = XW'(signed'(node_in));
    shifted = ext <<< GAIN_SHIFT;
    top     = shifted[XW-1:DATA_WIDTH-1];
    if ((&top) || (~|top)) begin
      conv_d = shifted[DATA_WIDTH-1:DATA_WIDTH-AUDIO_WIDTH];
    end else if (shifted[XW-1]) begin
      conv_d = {1'b1, {(AUDIO_WIDTH-1){1'b0}}};
    end else begin
      conv_d = {1'b0, {(AUDIO_WIDTH-1){1'b1}}};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      conv_valid_q <= 1'b0;
      conv_data_q  <= '0;
    end else begin
      conv_valid_q <= node_valid;
      if (node_valid) begin
        conv_data_q <= conv_d;
      end
    end
  end

  assign full  = (count_q == CW'(FIFO_DEPTH));
  assign empty = (count_q == '0);

  always_comb begin
    state_d        = state_q;
    pop            = 1'b0;
    underflow_evt  = 1'b0;
    audio_strobe_d = 1'b0;
    audio_data_d   = audio_data_q;
    case (state_q)
      ST_PRIME: begin
        if (audio_req) begin
          audio_strobe_d = 1'b1;
          audio_data_d   = '0;
        end
        if (count_q >= CW'(PRIME_LEVEL)) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (audio_req) begin
          audio_strobe_d = 1'b1;
          if (empty) begin
            underflow_evt = 1'b1;
            state_d       = ST_PRIME;
          end else begin
            pop          = 1'b1;
            audio_data_d = mem_q[rd_ptr_q];
          end
        end
      end
      default: state_d = ST_PRIME;
    endcase
  end

  // A pop frees the slot this cycle, so a full FIFO still accepts the write.
  always_comb begin
    push         = conv_valid_q && (!full || pop);
    overflow_evt = conv_valid_q && full && !pop;
    count_d      = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= conv_data_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= ST_PRIME;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      audio_data_q   <= '0;
      audio_strobe_q <= 1'b0;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      audio_data_q   <= audio_data_d;
      audio_strobe_q <= audio_strobe_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      overflow_q  <= overflow_evt  | (overflow_q  & ~clear_flags);
      underflow_q <= underflow_evt | (underflow_q & ~clear_flags);
    end
  end

  assign audio_data     = audio_data_q;
  assign audio_strobe   = audio_strobe_q;
  assign fifo_count     = count_q;
  assign overflow_flag  = overflow_q;
  assign underflow_flag = underflow_q;

endmodule

// File: tb/tb_drum_audio_bridge.sv
// tb/tb_drum_audio_bridge.sv - directed bench for drum_audio_bridge:
// conversion, priming, overflow, underflow, coincident events and reset.
module tb_drum_audio_bridge;

  logic        clock;
  logic        reset;
  logic [17:0] node_in;
  logic        node_valid;
  logic        audio_req;
  logic [15:0] audio_data;
  logic        audio_strobe;
  logic [3:0]  fifo_count;
  logic        overflow_flag;
  logic        underflow_flag;
  logic        clear_flags;

  int checks = 0;
  int errors = 0;

  drum_audio_bridge dut (
    .clock          (clock),
    .reset          (reset),
    .node_in        (node_in),
    .node_valid     (node_valid),
    .audio_req      (audio_req),
    .audio_data     (audio_data),
    .audio_strobe   (audio_strobe),
    .fifo_count     (fifo_count),
    .overflow_flag  (overflow_flag),
    .underflow_flag (underflow_flag),
    .clear_flags    (clear_flags)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [17:0] v);
    node_in    = v;
    node_valid = 1'b1;
    tick();
    node_valid = 1'b0;
  endtask

  task automatic req();
    audio_req = 1'b1;
    tick();
    audio_req = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset       = 1'b1;
    node_in     = '0;
    node_valid  = 1'b0;
    audio_req   = 1'b0;
    clear_flags = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check("rst_data",   32'(audio_data),     32'h0);
    check("rst_strobe", 32'(audio_strobe),   32'h0);
    check("rst_count",  32'(fifo_count),     32'h0);
    check("rst_ovf",    32'(overflow_flag),  32'h0);
    check("rst_udf",    32'(underflow_flag), 32'h0);

    // Priming with three samples: requests answer zero, nothing is popped.
    push(18'h01000);
    push(18'h3F000);
    push(18'h00003);
    tick();
    check("prime_count3", 32'(fifo_count), 32'h3);
    req();
    check("prime_data",   32'(audio_data),     32'h0);
    check("prime_strobe", 32'(audio_strobe),   32'h1);
    check("prime_count",  32'(fifo_count),     32'h3);
    check("prime_udf",    32'(underflow_flag), 32'h0);
    tick();
    check("strobe_pulse", 32'(audio_strobe), 32'h0);

    push(18'h08000);
    push(18'h20000);
    tick();
    check("run_count5", 32'(fifo_count), 32'h5);

    req();
    check("conv_pos",    32'(audio_data),   32'h1000);
    check("conv_strobe", 32'(audio_strobe), 32'h1);
    check("pop1_count",  32'(fifo_count),   32'h4);
    req();
    check("conv_neg",    32'(audio_data), 32'hF000);
    req();
    check("conv_small",  32'(audio_data), 32'h0003);
    req();
    check("conv_satpos", 32'(audio_data), 32'h7FFF);
    req();
    check("conv_satneg", 32'(audio_data), 32'h8000);
    check("drain_count", 32'(fifo_count), 32'h0);

    // Underflow: last sample repeats, then back in PRIME the output is zero.
    req();
    check("udf_data",   32'(audio_data),     32'h8000);
    check("udf_strobe", 32'(audio_strobe),   32'h1);
    check("udf_flag",   32'(underflow_flag), 32'h1);
    req();
    check("udf_prime_data", 32'(audio_data),     32'h0);
    check("udf_sticky",     32'(underflow_flag), 32'h1);
    clear_flags = 1'b1;
    tick();
    clear_flags = 1'b0;
    check("udf_clear", 32'(underflow_flag), 32'h0);

    // Overflow: ten samples into an eight-entry FIFO.
    for (int i = 1; i <= 10; i++) begin
      push(18'(i * 'h123));
    end
    tick();
    check("ovf_count", 32'(fifo_count),     32'h8);
    check("ovf_flag",  32'(overflow_flag),  32'h1);
    check("ovf_udf",   32'(underflow_flag), 32'h0);
    clear_flags = 1'b1;
    tick();
    clear_flags = 1'b0;
    check("ovf_clear", 32'(overflow_flag), 32'h0);

    // Full FIFO: write coincides with a pop, so nothing is dropped.
    node_in    = 18'h00AAA;
    node_valid = 1'b1;
    tick();
    node_valid = 1'b0;
    audio_req  = 1'b1;
    tick();
    audio_req  = 1'b0;
    check("simul_data",  32'(audio_data),    32'h0123);
    check("simul_count", 32'(fifo_count),    32'h8);
    check("simul_ovf",   32'(overflow_flag), 32'h0);

    // Overflow event in the same cycle as clear_flags keeps the flag set.
    node_in    = 18'h00BBB;
    node_valid = 1'b1;
    tick();
    node_valid  = 1'b0;
    clear_flags = 1'b1;
    tick();
    clear_flags = 1'b0;
    check("clr_vs_set_ovf", 32'(overflow_flag), 32'h1);
    check("clr_vs_set_cnt", 32'(fifo_count),    32'h8);

    for (int i = 2; i <= 8; i++) begin
      req();
      check($sformatf("order_%0d", i), 32'(audio_data), 32'(16'(i * 'h123)));
    end
    req();
    check("order_simul", 32'(audio_data), 32'h0AAA);
    check("order_empty", 32'(fifo_count), 32'h0);

    // Reset mid-stream with a sample in flight.
    for (int i = 1; i <= 5; i++) begin
      push(18'(18'h00100 + i));
    end
    tick();
    check("pre_rst_count", 32'(fifo_count), 32'h5);
    node_in    = 18'h00777;
    node_valid = 1'b1;
    reset      = 1'b1;
    tick();
    reset      = 1'b0;
    node_valid = 1'b0;
    check("mrst_count",  32'(fifo_count),     32'h0);
    check("mrst_data",   32'(audio_data),     32'h0);
    check("mrst_strobe", 32'(audio_strobe),   32'h0);
    check("mrst_ovf",    32'(overflow_flag),  32'h0);
    check("mrst_udf",    32'(underflow_flag), 32'h0);
    tick();
    check("mrst_inflight", 32'(fifo_count),   32'h0);
    check("mrst_strobe2",  32'(audio_strobe), 32'h0);
    req();
    check("mrst_req_strobe", 32'(audio_strobe),   32'h1);
    check("mrst_req_data",   32'(audio_data),     32'h0);
    check("mrst_req_udf",    32'(underflow_flag), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
